// File: rtl/arb_pkg.sv
// Shared types for the round-robin grant encoder.
// Index width, requester count and FSM state encodings.
package arb_pkg;

    localparam int IDX_W = 3;
    localparam int N_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select: first set request at or
// after ptr, scanning upward with wrap.
import arb_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] win
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    always_comb begin
        dbl = {req, req};
        // rot[0] is req[ptr], so the lowest set bit is the nearest requester
        rot = dbl[ptr +: N_REQ];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        found = |req;
        win   = off + ptr;
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter driving a 3-to-8 decoder's Enable/A/B/C inputs.
// Grants are held until release, requester drop or timeout.
import arb_pkg::*;

module rr_grant_encoder #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N_REQ-1:0] Req,
    input  logic             Release,
    output logic             Enable,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             Timeout
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               to_q, to_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic               rel;
    logic               drop;
    logic               tmo;

    rr_pick u_pick (
        .req   (Req),
        .ptr   (ptr_q),
        .found (found),
        .win   (win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        rel     = Release;
        drop    = ~Req[idx_q];
        tmo     = (hold_q == HOLD_W'(MAX_HOLD));
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    idx_d   = win;
                    hold_d  = HOLD_W'(1);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel || drop || tmo) begin
                    state_d = ST_GAP;
                    ptr_d   = idx_q + 1'b1;
                    // Timeout flags only a revoke the owner did not cause
                    to_d    = ~rel & ~drop;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign Enable    = (state_q == ST_GRANT);
    assign {A, B, C} = idx_q;
    assign Timeout   = to_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder: a cycle reference model queues
// expected outputs, a monitor compares them 1 ns after each rising edge.
module tb_rr_grant_encoder;

    localparam int MAXH = 15;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic       tmo;
    logic [7:0] f;

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    typedef struct {
        bit en;
        int idx;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    int   grants[$];

    // reference state
    bit m_busy = 0;
    bit m_gap  = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_hold = 0;
    bit m_to   = 0;

    rr_grant_encoder #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .Req     (req),
        .Release (rel),
        .Enable  (en),
        .A       (a),
        .B       (b),
        .C       (c),
        .Timeout (tmo)
    );

    // downstream 3-to-8 decoder
    assign f = en ? (8'b1 << {a, b, c}) : 8'b0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: advance on each rising edge from sampled inputs
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m_busy = 0; m_gap = 0; m_ptr = 0;
            m_idx = 0; m_hold = 0; m_to = 0;
        end else if (m_gap) begin
            m_gap = 0;
            m_to  = 0;
        end else if (m_busy) begin
            m_to = 0;
            if (rel || !req[m_idx] || m_hold == MAXH) begin
                m_to   = !rel && req[m_idx];
                m_busy = 0;
                m_gap  = 1;
                m_ptr  = (m_idx + 1) % 8;
            end else begin
                m_hold++;
            end
        end else begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_ptr + k) % 8]) begin
                    m_idx  = (m_ptr + k) % 8;
                    m_hold = 1;
                    m_busy = 1;
                end
            end
        end
        e.en  = m_busy;
        e.idx = m_idx;
        e.to  = m_to;
        if (!done) exp_q.push_back(e);
    end

    // monitor
    always @(posedge clk) begin
        exp_t e;
        logic [7:0] fe;
        #1;
        if (exp_q.size() == 0) begin
            if (!done) chk("queue_empty", 8'd0, 8'd1);
        end else begin
            e  = exp_q.pop_front();
            fe = e.en ? (8'b1 << e.idx) : 8'b0;
            chk("enable", {7'd0, en}, {7'd0, e.en});
            chk("abc", {5'd0, a, b, c}, 8'(e.idx));
            chk("timeout", {7'd0, tmo}, {7'd0, e.to});
            chk("dec_f", f, fe);
            if (en === 1'b1 && exp_q.size() >= 0 && !rst)
                if (grants.size() == 0 || !e.en || 1) ;
        end
    end

    // grant-start log for the fairness check
    logic prev_en = 0;
    always @(posedge clk) begin
        #2;
        if (en === 1'b1 && !prev_en) grants.push_back({29'd0, a, b, c});
        prev_en = (en === 1'b1);
    end

    task automatic cyc(input logic [7:0] r, input logic rl, input logic rs);
        req = r;
        rel = rl;
        rst = rs;
        @(negedge clk);
    endtask

    initial begin
        req = 0; rel = 0; rst = 1;
        @(negedge clk);
        cyc(8'h00, 0, 1);
        grants.delete();
        // fairness: all requesting, each releasing
        repeat (30) cyc(8'hFF, 1, 0);
        if (grants.size() < 9) begin
            chk("fair_count", 8'(grants.size()), 8'd9);
        end else begin
            for (int i = 0; i < 9; i++)
                chk("fair_order", 8'(grants[i]), 8'(i % 8));
        end
        // single requester 3
        cyc(8'h00, 0, 1);
        repeat (4) cyc(8'h08, 0, 0);
        cyc(8'h08, 1, 0);
        repeat (2) cyc(8'h00, 0, 0);
        // alternate 0 and 7
        cyc(8'h00, 0, 1);
        repeat (12) cyc(8'h81, 1, 0);
        // wrap of ptr after idx 6
        cyc(8'h00, 0, 1);
        repeat (3) cyc(8'h40, 1, 0);
        repeat (8) cyc(8'h84, 1, 0);
        // timeout then hand-over to 5
        cyc(8'h00, 0, 1);
        repeat (40) cyc(8'h24, 0, 0);
        // requester drop
        cyc(8'h00, 0, 1);
        repeat (4) cyc(8'h02, 0, 0);
        repeat (3) cyc(8'h00, 0, 0);
        // release coincides with hold limit
        cyc(8'h00, 0, 1);
        repeat (15) cyc(8'h02, 0, 0);
        cyc(8'h02, 1, 0);
        repeat (3) cyc(8'h02, 0, 0);
        // reset mid-grant
        repeat (4) cyc(8'h08, 0, 0);
        cyc(8'h08, 0, 1);
        repeat (6) cyc(8'hFF, 1, 0);
        // random traffic
        begin
            logic [7:0] r;
            r = 8'($urandom);
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 7) == 0) r = 8'($urandom);
                cyc(r, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 299) == 0);
            end
        end
        repeat (2) cyc(8'h00, 0, 0);
        done = 1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
